// File: rtl/alu_pkg.sv
// Shared opcode encodings, opcode-class helpers and FSM state type for the
// ALU sharing controller.
package alu_pkg;

  localparam logic [3:0] OP_CLR = 4'b0000;
  localparam logic [3:0] OP_INC = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_MAD = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b0101;
  localparam logic [3:0] OP_LT  = 4'b0110;
  localparam logic [3:0] OP_GT  = 4'b0111;
  localparam logic [3:0] OP_NEQ = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } share_state_t;

  function automatic logic is_setp(input logic [3:0] op);
    return (op >= OP_EQ) && (op <= OP_NEQ);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_NEQ;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bus between the issue lanes, the consumer and the ALU
// sharing controller.
interface alu_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [16*NREQ-1:0] req_c;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_data;
  logic               rsp_pred;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_pred, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_pred, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Shared 16-bit ALU datapath: arithmetic result and unsigned SETP predicate,
// both wrapping modulo 2^16.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  output logic [15:0] alu_out_o,
  output logic        p_o
);

  logic [15:0] mul_ab;
  logic [15:0] mul_bc;

  assign mul_ab = a_i * b_i;
  assign mul_bc = b_i * c_i;

  always_comb begin
    alu_out_o = '0;
    p_o       = 1'b0;
    case (op_i)
      OP_CLR:  alu_out_o = '0;
      OP_INC:  alu_out_o = a_i + 16'd1;
      OP_ADD:  alu_out_o = a_i + b_i;
      OP_MUL:  alu_out_o = mul_ab;
      OP_MAD:  alu_out_o = a_i + mul_bc;
      OP_EQ:   p_o = (a_i == b_i);
      OP_LT:   p_o = (a_i <  b_i);
      OP_GT:   p_o = (a_i >  b_i);
      OP_NEQ:  p_o = (a_i != b_i);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational winner selector: one-hot grant plus index. Round-robin from
// ptr_i when ALU_SHARE_RR_EN is defined, otherwise lowest lane index wins.
module alu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] valid_i,
`ifdef ALU_SHARE_RR_EN
  input  logic [IDW-1:0]  ptr_i,
`endif
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
`ifdef ALU_SHARE_RR_EN
    // Rank k is lane (ptr+k) mod NREQ; first valid rank wins.
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_o && valid_i[j] &&
            ((int'(ptr_i) + k == j) || (int'(ptr_i) + k == j + NREQ))) begin
          any_o      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = IDW'(j);
        end
      end
    end
`else
    for (int j = 0; j < NREQ; j++) begin
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
`endif
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one 16-bit ALU among NREQ lanes: grant, execute, tagged response.
// ALU_SHARE_RR_EN selects round-robin arbitration; undefined gives fixed priority.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic             busy
);

  share_state_t   state_q;
  logic [3:0]     op_q;
  logic [15:0]    a_q, b_q, c_q;
  logic [IDW-1:0] id_q;
  logic [15:0]    rsp_data_q;
  logic           rsp_pred_q;
  logic           rsp_err_q;
  logic [IDW-1:0] rsp_id_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic [3:0]      sel_op;
  logic [15:0]     sel_a, sel_b, sel_c;
  logic [15:0]     alu_out;
  logic            alu_p;

`ifdef ALU_SHARE_RR_EN
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;

  assign ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid_i (bus.req_valid),
`ifdef ALU_SHARE_RR_EN
    .ptr_i   (ptr_q),
`endif
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Payload of the granted lane; grant is one-hot so an OR-mux suffices.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op = sel_op | bus.req_op[4*i +: 4];
        sel_a  = sel_a  | bus.req_a[16*i +: 16];
        sel_b  = sel_b  | bus.req_b[16*i +: 16];
        sel_c  = sel_c  | bus.req_c[16*i +: 16];
      end
    end
  end

  alu u_alu (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .c_i       (c_q),
    .alu_out_o (alu_out),
    .p_o       (alu_p)
  );

  assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_pred  = rsp_pred_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_pred_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
`ifdef ALU_SHARE_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            c_q     <= sel_c;
            id_q    <= win_idx;
`ifdef ALU_SHARE_RR_EN
            ptr_q   <= ptr_d;
`endif
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Class masking: only the field matching the op class is returned.
          rsp_err_q  <= !is_legal(op_q);
          rsp_data_q <= (is_legal(op_q) && !is_setp(op_q)) ? alu_out : '0;
          rsp_pred_q <= (is_legal(op_q) &&  is_setp(op_q)) ? alu_p : 1'b0;
          rsp_id_q   <= id_q;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed plus randomized bench for alu_share_ctrl against a behavioural
// model of arbitration and opcode semantics; honours ALU_SHARE_RR_EN.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  alu_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;
  int last_id = -1;
  int exp_order[5];

  logic [NREQ-1:0] lane_vld;
  logic [3:0]      lane_op[NREQ];
  logic [15:0]     lane_a[NREQ];
  logic [15:0]     lane_b[NREQ];
  logic [15:0]     lane_c[NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus();
    bus.req_valid = lane_vld;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[4*i +: 4]  = lane_op[i];
      bus.req_a[16*i +: 16] = lane_a[i];
      bus.req_b[16*i +: 16] = lane_b[i];
      bus.req_c[16*i +: 16] = lane_c[i];
    end
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c);
    lane_op[l] = op;
    lane_a[l]  = a;
    lane_b[l]  = b;
    lane_c[l]  = c;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v);
`ifdef ALU_SHARE_RR_EN
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  // Opcode semantics computed with plain unsigned integer arithmetic.
  task automatic ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, output logic [15:0] d, output logic p,
                         output logic e);
    int unsigned ua, ub, uc;
    ua = a; ub = b; uc = c;
    d = '0; p = 1'b0; e = 1'b0;
    case (op)
      4'd0: d = 16'h0000;
      4'd1: d = 16'((ua + 1) % 65536);
      4'd2: d = 16'((ua + ub) % 65536);
      4'd3: d = 16'((ua * ub) % 65536);
      4'd4: d = 16'((ua + ub * uc) % 65536);
      4'd5: p = (ua == ub);
      4'd6: p = (ua <  ub);
      4'd7: p = (ua >  ub);
      4'd8: p = (ua != ub);
      default: e = 1'b1;
    endcase
  endtask

  // One arbitration round starting in IDLE at posedge+1; returns in IDLE.
  task automatic serve(input int stall, input bit keep);
    int w;
    logic [15:0] ed;
    logic ep, ee;
    logic [NREQ-1:0] eg;
    drive_bus();
    #1;
    w  = model_pick(lane_vld);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("req_ready_grant", 32'(bus.req_ready), 32'(eg));
    if (w < 0) begin
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      return;
    end
    ref_alu(lane_op[w], lane_a[w], lane_b[w], lane_c[w], ed, ep, ee);
    ptr_m   = (w + 1) % NREQ;
    last_id = w;
    bus.rsp_ready = (stall == 0);
    step();
    if (!keep) lane_vld[w] = 1'b0;
    drive_bus();
    #1;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(w));
    chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
    chk("rsp_pred", 32'(bus.rsp_pred), 32'(ep));
    chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_data", 32'(bus.rsp_data), 32'(ed));
      chk("stall_rsp_id", 32'(bus.rsp_id), 32'(w));
      chk("stall_rsp_pred", 32'(bus.rsp_pred), 32'(ep));
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("back_idle_busy", 32'(busy), 32'd0);
    chk("back_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    lane_vld = '0;
    for (int i = 0; i < NREQ; i++) set_lane(i, 4'd0, 16'd0, 16'd0, 16'd0);
    bus.rsp_ready = 1'b1;
    drive_bus();
    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_pred", 32'(bus.rsp_pred), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ptr_m = 0;

    // Lane 2 ADD alone.
    set_lane(2, OP_ADD, 16'h1234, 16'h0101, 16'h0000);
    lane_vld = 4'b0100;
    serve(0, 1'b0);
    chk("add_lane2_data", 32'(bus.rsp_data), 32'h1335);

    // MAD / MUL wrap.
    set_lane(0, OP_MAD, 16'hFFFF, 16'd2, 16'd3);
    lane_vld = 4'b0001;
    serve(0, 1'b0);
    chk("mad_wrap_data", 32'(bus.rsp_data), 32'h0005);
    set_lane(1, OP_MUL, 16'h0100, 16'h0100, 16'h0000);
    lane_vld = 4'b0010;
    serve(0, 1'b0);
    chk("mul_wrap_data", 32'(bus.rsp_data), 32'h0000);

    // Continuous requests on all lanes from a freshly reset pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
`ifdef ALU_SHARE_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < NREQ; i++) set_lane(i, OP_ADD, 16'(i * 16'h0111), 16'h0010, 16'h0000);
    lane_vld = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve(0, 1'b1);
      chk("grant_order", 32'(last_id), 32'(exp_order[g]));
    end

    // SETP and illegal opcode.
    set_lane(3, OP_LT, 16'd1, 16'd2, 16'd0);
    lane_vld = 4'b1000;
    serve(0, 1'b0);
    chk("lt_pred", 32'(bus.rsp_pred), 32'd1);
    chk("lt_data", 32'(bus.rsp_data), 32'd0);
    set_lane(1, 4'b1100, 16'hAAAA, 16'h5555, 16'h0001);
    lane_vld = 4'b0010;
    serve(0, 1'b0);
    chk("illegal_err", 32'(bus.rsp_err), 32'd1);
    chk("illegal_data", 32'(bus.rsp_data), 32'd0);

    // Backpressure with other lanes pending.
    set_lane(0, OP_INC, 16'hFFFF, 16'd0, 16'd0);
    set_lane(2, OP_GT, 16'h8000, 16'h7FFF, 16'd0);
    lane_vld = 4'b0101;
    serve(5, 1'b0);
    serve(0, 1'b0);

    // Reset while in EXEC drops the transaction and clears the pointer.
    set_lane(1, OP_ADD, 16'd7, 16'd8, 16'd0);
    lane_vld = 4'b0010;
    drive_bus();
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'b0010);
    step();
    lane_vld = '0;
    drive_bus();
    chk("pre_rst_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    step();
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    set_lane(0, OP_INC, 16'd41, 16'd0, 16'd0);
    set_lane(2, OP_INC, 16'd99, 16'd0, 16'd0);
    lane_vld = 4'b0101;
    serve(0, 1'b0);
    chk("post_rst_first_grant", 32'(last_id), 32'd0);
    lane_vld = '0;

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!lane_vld[i] && ($urandom_range(0, 1) == 1)) begin
          logic [15:0] v[3];
          for (int k = 0; k < 3; k++) begin
            case ($urandom_range(0, 3))
              0:       v[k] = 16'h0000;
              1:       v[k] = 16'hFFFF;
              default: v[k] = 16'($urandom);
            endcase
          end
          set_lane(i, 4'($urandom_range(0, 15)), v[0], v[1], v[2]);
          lane_vld[i] = 1'b1;
        end
      end
      serve($urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
